// File: rtl/incoming_response_buffer_if.sv
// R-channel beat interface shared by the AXI slave side and the ordering unit side.
interface r_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2
);
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport receiver (input id, data, resp, last, valid, output ready);
  modport sender   (output id, data, resp, last, valid, input ready);
endinterface

// File: rtl/incoming_response_buffer.sv
// In-order FIFO for AXI R beats between the slave and r_ordering_unit.
// Optional high-water-mark output enabled by INCOMING_RESP_BUF_STATS_EN.
module incoming_response_buffer #(
  parameter int ID_WIDTH     = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int RESP_WIDTH   = 2,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  r_if.receiver                      r_in,
  r_if.sender                        r_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] bursts,
  output logic                       almost_full,
  output logic                       err_seen,
  input  logic                       err_clr
`ifdef INCOMING_RESP_BUF_STATS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] hwm
`endif
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1;

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CNT_W-1:0]   count_r, count_nxt_s, bursts_r, bursts_nxt_s;
  logic               afull_r, afull_nxt_s, err_r, err_nxt_s;
  logic               full_s, empty_s, push_s, pop_s, push_last_s, pop_last_s;
  logic [ENTRY_W-1:0] head_s;

  // Handshake decode, head selection and next-state computation.
  always_comb begin
    full_s       = (count_r == CNT_W'(DEPTH));
    empty_s      = (count_r == {CNT_W{1'b0}});
    push_s       = r_in.valid & ~full_s;
    pop_s        = ~empty_s & r_out.ready;
    head_s       = {ENTRY_W{1'b0}};
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    bursts_nxt_s = bursts_r;
    err_nxt_s    = err_r;

    if (~empty_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = {ENTRY_W{1'b0}};
    end
    push_last_s = push_s & r_in.last;
    pop_last_s  = pop_s & head_s[0];

    if (push_s) begin
      if (wr_ptr_r == PTR_W'(DEPTH-1)) begin
        wr_ptr_nxt_s = {PTR_W{1'b0}};
      end else begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
      end
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      if (rd_ptr_r == PTR_W'(DEPTH-1)) begin
        rd_ptr_nxt_s = {PTR_W{1'b0}};
      end else begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      end
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase

    case ({push_last_s, pop_last_s})
      2'b10:   bursts_nxt_s = bursts_r + CNT_W'(1);
      2'b01:   bursts_nxt_s = bursts_r - CNT_W'(1);
      default: bursts_nxt_s = bursts_r;
    endcase

    // An error beat arriving with err_clr keeps the flag set.
    if (push_s & r_in.resp[1]) begin
      err_nxt_s = 1'b1;
    end else if (err_clr) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r;
    end

    afull_nxt_s = (count_nxt_s >= CNT_W'(AFULL_THRESH));
  end

  // Control state; reset discards all buffered beats immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      bursts_r <= {CNT_W{1'b0}};
      afull_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      bursts_r <= bursts_nxt_s;
      afull_r  <= afull_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

  // Beat storage; contents are qualified by count so need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {r_in.id, r_in.data, r_in.resp, r_in.last};
    end
  end

`ifdef INCOMING_RESP_BUF_STATS_EN
  logic [CNT_W-1:0] hwm_r;

  // Peak occupancy since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm_r <= {CNT_W{1'b0}};
    end else if (count_nxt_s > hwm_r) begin
      hwm_r <= count_nxt_s;
    end else begin
      hwm_r <= hwm_r;
    end
  end

  assign hwm = hwm_r;
`endif

  assign r_in.ready  = ~full_s;
  assign r_out.valid = ~empty_s;
  assign {r_out.id, r_out.data, r_out.resp, r_out.last} = head_s;
  assign count       = count_r;
  assign bursts      = bursts_r;
  assign almost_full = afull_r;
  assign err_seen    = err_r;

endmodule
